// File: rtl/arith_cmd_issuer.sv
`timescale 1ns/1ps
// arith_cmd_issuer
//
// Initiator-side sequencer for the multicycle arithmetic unit. Commands
// {op, a, b} are queued in a DEPTH-entry FIFO. They are issued one at a time
// with a single-cycle `start` pulse, and the unit's result is returned in
// command order on a response port.
//
// Handshakes: both ports use strict valid/ready. A transfer happens on a
// rising edge where valid && ready are both high. The producer holds valid
// and its payload stable until that edge. On the response port, rsp_valid
// and rsp_data/rsp_op/rsp_err are held until rsp_ready is seen. cmd_ready is
// a pure function of FIFO fullness and never depends on cmd_valid.
//
// Optional feature: define ARITH_ISSUER_TIMEOUT_EN to enable a WAIT
// watchdog. After TIMEOUT cycles without a qualified done, it returns a
// response with rsp_err=1 and rsp_data=0. Without it, rsp_err is constant 0.
//
// Parameters: W (operand width, result 2*W), DEPTH (FIFO entries, power of
//   two >= 2), TIMEOUT (watchdog cycles, watchdog builds only).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op/cmd_a/cmd_b payload
//   start, op, a, b      issue pulse and held operands to the unit
//   done, result         completion and result from the unit
//   rsp_valid/rsp_ready  response handshake; rsp_data/rsp_op/rsp_err payload
//   issued_cnt           number of start pulses, wraps at 8 bits
//   dbg_state            FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
module arith_cmd_issuer #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  output logic           start,
  output logic [1:0]     op,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  input  logic           done,
  input  logic [2*W-1:0] result,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic [1:0]     rsp_op,
  output logic           rsp_err,
  output logic [7:0]     issued_cnt,
  output logic [1:0]     dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + 2 * W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nx;

  // ---------------------------------------------------------------------
  // Command FIFO. The pointers carry one extra wrap bit, so full and empty
  // are told apart without an occupancy counter.
  // ---------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [EW-1:0] head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // cmd_ready ignores a same-cycle pop, so a full FIFO never accepts.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  // The head is consumed on the edge that enters ISSUE. The operands are
  // therefore already on op/a/b during the start cycle.
  assign pop        = (state_nx == ISSUE);
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // ---------------------------------------------------------------------
  // done qualification: after an issue, a done is only believed once done
  // has been sampled low at least once. A stale high level left over from
  // the previous operation is therefore never taken as this one's
  // completion.
  // ---------------------------------------------------------------------
  logic done_low_seen;
  logic done_ok;
  logic tmo_hit;

  assign done_ok = (state == WAIT) && done && done_low_seen;

`ifdef ARITH_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // tmo_cnt counts completed WAIT cycles. The watchdog fires in the
  // TIMEOUT-th WAIT cycle, so RESP follows TIMEOUT+1 cycles after start.
  assign tmo_hit = (state == WAIT) && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (done_ok) begin
        rsp_err <= 1'b0;
      end else if (tmo_hit) begin
        rsp_err <= 1'b1;
      end
    end
  end
`else
  // Watchdog compiled out. This folds to 0 for any legal TIMEOUT.
  assign tmo_hit = (TIMEOUT < 1);
  assign rsp_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (done_ok || tmo_hit) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = fifo_empty ? IDLE : ISSUE;
      default: state_nx = IDLE;
    endcase
  end

  assign start     = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // State, pointers, issue registers and response capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      op            <= '0;
      a             <= '0;
      b             <= '0;
      issued_cnt    <= '0;
      rsp_data      <= '0;
      rsp_op        <= '0;
      done_low_seen <= 1'b0;
    end else begin
      state <= state_nx;

      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end

      // op/a/b only change here, so they stay put through WAIT and RESP.
      if (pop) begin
        rd_ptr       <= rd_ptr + (AW + 1)'(1);
        {op, a, b}   <= head;
        issued_cnt   <= issued_cnt + 8'd1;
      end

      if (pop) begin
        done_low_seen <= 1'b0;
      end else if (((state == ISSUE) || (state == WAIT)) && !done) begin
        done_low_seen <= 1'b1;
      end

      // A qualified done wins over a watchdog expiry in the same cycle.
      if (done_ok) begin
        rsp_data <= result;
        rsp_op   <= op;
      end else if (tmo_hit) begin
        rsp_data <= '0;
        rsp_op   <= op;
      end
    end
  end

endmodule
